datapath_unit: RTL and testbench
================================

# datapath_unit

Processor datapath directly downstream of the control unit: consumes its data-memory, register-file and ALU control outputs and executes them. Contains a 16-entry register file with two read ports and two write paths, a 256-word data memory with synchronous read, and a 3-bit-select ALU with registered result and zero flag. Register and memory contents feed back to the control unit only through the instruction stream; outputs here are for observation and display.

## Interface
- DATA_W, 16, datapath word width (RF, ALU, data memory)
- DMEM_AW, 8, data memory address width (2^DMEM_AW words)
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset (0 = reset)
- D_addr  in  DMEM_AW  data memory address
- D_wr  in  1  data memory write enable
- RF_WenA  in  1  write Mem_q into R[RF_Ra_addr]
- RF_WenB  in  1  write ALU result into R[RF_Rb_addr]
- RF_Ra_addr  in  4  read port A address / write-A address
- RF_Rb_addr  in  4  read port B address / write-B address
- ALU_S  in  3  ALU function select
- Ra_data  out  DATA_W  R[RF_Ra_addr], combinational read
- Rb_data  out  DATA_W  R[RF_Rb_addr], combinational read
- Mem_q  out  DATA_W  registered data memory read data
- ALU_Out  out  DATA_W  registered ALU result
- Zero  out  1  registered, 1 when last ALU result written was 0

## Operation
- Reset low (any time, async): all 16 registers, Mem_q, ALU_Out cleared to 0; Zero cleared to 0. Data memory contents not reset. Held in reset while Reset=0; first update on first rising Clk after release.
- ALU (combinational, A=Ra_data, B=Rb_data), result mod 2^DATA_W, no carry out:
  - 000 A; 001 A+B; 010 A−B; 011 A&B; 100 A|B; 101 A^B; 110 ~A; 111 0.
- ALU_Out loads ALU result every rising edge regardless of enables.
- Zero loads (result==0) only on edges with RF_WenB=1; holds otherwise.
- RF write A: RF_WenA=1 -> R[RF_Ra_addr] <= Mem_q (value of Mem_q before the edge).
- RF write B: RF_WenB=1 -> R[RF_Rb_addr] <= ALU result.
- Both enables, different addresses: both writes occur.
- Both enables, same address (Ra_addr==Rb_addr): write B (ALU) wins.
- Data memory write: D_wr=1 -> mem[D_addr] <= Ra_data.
- Data memory read: Mem_q <= mem[D_addr] every rising edge; on D_wr=1 to same address Mem_q gets old contents (read-before-write).
- Register 0 is an ordinary writable register; no hardwired zero.

## Timing
- RF read: zero latency; write visible on Ra_data/Rb_data after the writing edge.
- RF read-during-write same cycle: read ports show old value until edge.
- Load (memory -> RF) is 2 cycles: cycle N present D_addr; edge N loads Mem_q; cycle N+1 assert RF_WenA with RF_Ra_addr; edge N+1 writes. The control unit sequences this; no internal handshake.
- Store (RF -> memory): 1 cycle; D_addr, RF_Ra_addr, D_wr valid together.
- ALU op (RF -> ALU -> RF): 1 cycle; ALU_Out and Zero reflect it after the same edge.
- D_addr wrap: full DMEM_AW range addressable, no out-of-range case.
- Reset asserted mid-load: Mem_q cleared, so a subsequent RF_WenA writes 0.

## Test plan
- Reset: preload R3 via ALU path, pull Reset low between edges -> Ra_data for addr 3, ALU_Out, Mem_q, Zero all 0 immediately, before next edge.
- ALU coverage: R1=0x0005, R2=0x0003, cycle all ALU_S -> results 0005, 0008, 0002, 0001, 0007, 0006, FFFA, 0000; A−B with R1=0, R2=1 -> FFFF; 0xFFFF+1 -> 0000 with Zero=1 when written.
- Store/load: R4=0xBEEF, D_wr at addr 0x80; later D_addr=0x80, next cycle RF_WenA to R7 -> R7=0xBEEF; Mem_q valid exactly one edge after address.
- Read-before-write: mem[0x10]=0x1111, D_wr=1 at 0x10 with Ra_data=0x2222 -> Mem_q=0x1111 after edge, 0x2222 after following edge.
- Write collision: RF_WenA and RF_WenB both 1, Ra_addr=Rb_addr=5, Mem_q=0xAAAA, ALU result 0x5555 -> R5=0x5555; with Ra_addr=5, Rb_addr=6 -> R5=0xAAAA, R6=0x5555.
- Zero hold: ALU op giving 0 with RF_WenB=0 -> Zero unchanged; same op with RF_WenB=1 -> Zero=1.

Source files
------------

// File: rtl/datapath_unit.sv
// datapath_unit: register file, data memory and ALU executing the control
// unit's decoded controls. Register and memory contents are observable only.
module datapath_unit #(
  parameter int DATA_W  = 16,
  parameter int DMEM_AW = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [DMEM_AW-1:0] D_addr,
  input  logic               D_wr,
  input  logic               RF_WenA,
  input  logic               RF_WenB,
  input  logic [3:0]         RF_Ra_addr,
  input  logic [3:0]         RF_Rb_addr,
  input  logic [2:0]         ALU_S,
  output logic [DATA_W-1:0]  Ra_data,
  output logic [DATA_W-1:0]  Rb_data,
  output logic [DATA_W-1:0]  Mem_q,
  output logic [DATA_W-1:0]  ALU_Out,
  output logic               Zero
);

  localparam int DMEM_DEPTH = 1 << DMEM_AW;

  logic [DATA_W-1:0] reg_file [16];
  logic [DATA_W-1:0] data_mem [DMEM_DEPTH];
  logic [DATA_W-1:0] alu_result;

  // Both read ports are zero-latency so the ALU sees operands in the same cycle.
  assign Ra_data = reg_file[RF_Ra_addr];
  assign Rb_data = reg_file[RF_Rb_addr];

  // ALU function decode; arithmetic wraps modulo 2^DATA_W with no carry out.
  always_comb begin
    alu_result = '0;
    case (ALU_S)
      3'b000:  alu_result = Ra_data;
      3'b001:  alu_result = Ra_data + Rb_data;
      3'b010:  alu_result = Ra_data - Rb_data;
      3'b011:  alu_result = Ra_data & Rb_data;
      3'b100:  alu_result = Ra_data | Rb_data;
      3'b101:  alu_result = Ra_data ^ Rb_data;
      3'b110:  alu_result = ~Ra_data;
      default: alu_result = '0;
    endcase
  end

  // Register file writes; the ALU path is assigned last so it wins an address collision.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin
        reg_file[i] <= '0;
      end
    end else begin
      if (RF_WenA) begin
        reg_file[RF_Ra_addr] <= Mem_q;
      end
      if (RF_WenB) begin
        reg_file[RF_Rb_addr] <= alu_result;
      end
    end
  end

  // Data memory storage is never cleared, so it stays a plain RAM array.
  always_ff @(posedge Clk) begin
    if (D_wr) begin
      data_mem[D_addr] <= Ra_data;
    end
  end

  // Synchronous read port; a write to the same address returns the old word.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Mem_q <= '0;
    end else begin
      Mem_q <= data_mem[D_addr];
    end
  end

  // ALU result registers every cycle; the zero flag only tracks results written back.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ALU_Out <= '0;
      Zero    <= 1'b0;
    end else begin
      ALU_Out <= alu_result;
      if (RF_WenB) begin
        Zero <= (alu_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// tb_datapath_unit: directed vectors and hand-written sequences for datapath_unit.
module tb_datapath_unit;

  logic        Clk;
  logic        Reset;
  logic [7:0]  D_addr;
  logic        D_wr;
  logic        RF_WenA;
  logic        RF_WenB;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  ALU_S;
  logic [15:0] Ra_data;
  logic [15:0] Rb_data;
  logic [15:0] Mem_q;
  logic [15:0] ALU_Out;
  logic        Zero;

  int checks;
  int failures;

  typedef struct {
    logic [2:0]  alu_s;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        wen_b;
    logic [15:0] exp_alu;
    logic        exp_zero;
    logic [15:0] exp_rb;
  } vec_t;

  vec_t vecs [13];

  datapath_unit #(.DATA_W(16), .DMEM_AW(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_WenA    (RF_WenA),
    .RF_WenB    (RF_WenB),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_S      (ALU_S),
    .Ra_data    (Ra_data),
    .Rb_data    (Rb_data),
    .Mem_q      (Mem_q),
    .ALU_Out    (ALU_Out),
    .Zero       (Zero)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    D_wr       = 1'b0;
    RF_WenA    = 1'b0;
    RF_WenB    = 1'b0;
    ALU_S      = 3'b000;
  endtask

  // One ALU cycle with optional write-back to R[rb].
  task automatic applyStimulus(input logic [2:0] s, input logic [3:0] ra, input logic [3:0] rb, input logic wb);
    idleInputs();
    ALU_S      = s;
    RF_Ra_addr = ra;
    RF_Rb_addr = rb;
    RF_WenB    = wb;
    tick();
    RF_WenB    = 1'b0;
  endtask

  // Build a constant in R[t] by shift-and-add, using R15 == 1.
  task automatic loadConst(input logic [3:0] t, input logic [15:0] value);
    applyStimulus(3'b111, t, t, 1'b1);
    for (int i = 15; i >= 0; i--) begin
      applyStimulus(3'b001, t, t, 1'b1);
      if (value[i]) applyStimulus(3'b001, 4'd15, t, 1'b1);
    end
  endtask

  task automatic storeReg(input logic [3:0] ra, input logic [7:0] addr);
    idleInputs();
    RF_Ra_addr = ra;
    D_addr     = addr;
    D_wr       = 1'b1;
    tick();
    D_wr       = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset      = 1'b0;
    D_addr     = 8'h00;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    idleInputs();
    tick();
    tick();
    #2;
    Reset = 1'b1;
    tick();
    checkOutput("reset_ra", Ra_data, 16'h0000);
    checkOutput("reset_alu", ALU_Out, 16'h0000);
    checkOutput("reset_memq", Mem_q, 16'h0000);
    checkOutput("reset_zero", {15'd0, Zero}, 16'h0000);

    // R15 = 1: clear, invert to FFFF, then R13(0) - FFFF.
    applyStimulus(3'b111, 4'd15, 4'd15, 1'b1);
    applyStimulus(3'b110, 4'd15, 4'd15, 1'b1);
    applyStimulus(3'b010, 4'd13, 4'd15, 1'b1);
    RF_Ra_addr = 4'd15;
    #1;
    checkOutput("setup_r15", Ra_data, 16'h0001);
    loadConst(4'd1, 16'h0005);
    loadConst(4'd2, 16'h0003);
    RF_Ra_addr = 4'd1;
    RF_Rb_addr = 4'd2;
    #1;
    checkOutput("setup_r1", Ra_data, 16'h0005);
    checkOutput("setup_r2", Rb_data, 16'h0003);

    vecs[0]  = '{3'b000, 4'd1,  4'd2,  1'b0, 16'h0005, 1'b0, 16'h0003};
    vecs[1]  = '{3'b001, 4'd1,  4'd2,  1'b0, 16'h0008, 1'b0, 16'h0003};
    vecs[2]  = '{3'b010, 4'd1,  4'd2,  1'b0, 16'h0002, 1'b0, 16'h0003};
    vecs[3]  = '{3'b011, 4'd1,  4'd2,  1'b0, 16'h0001, 1'b0, 16'h0003};
    vecs[4]  = '{3'b100, 4'd1,  4'd2,  1'b0, 16'h0007, 1'b0, 16'h0003};
    vecs[5]  = '{3'b101, 4'd1,  4'd2,  1'b0, 16'h0006, 1'b0, 16'h0003};
    vecs[6]  = '{3'b110, 4'd1,  4'd2,  1'b0, 16'hFFFA, 1'b0, 16'h0003};
    vecs[7]  = '{3'b111, 4'd1,  4'd2,  1'b0, 16'h0000, 1'b0, 16'h0003};
    vecs[8]  = '{3'b111, 4'd1,  4'd9,  1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{3'b010, 4'd9,  4'd15, 1'b0, 16'hFFFF, 1'b1, 16'h0001};
    vecs[10] = '{3'b110, 4'd9,  4'd10, 1'b1, 16'hFFFF, 1'b0, 16'hFFFF};
    vecs[11] = '{3'b001, 4'd15, 4'd10, 1'b1, 16'h0000, 1'b1, 16'h0000};
    vecs[12] = '{3'b011, 4'd1,  4'd2,  1'b1, 16'h0001, 1'b0, 16'h0001};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].alu_s, vecs[i].ra, vecs[i].rb, vecs[i].wen_b);
      checkOutput($sformatf("vec%0d_alu", i), ALU_Out, vecs[i].exp_alu);
      checkOutput($sformatf("vec%0d_zero", i), {15'd0, Zero}, {15'd0, vecs[i].exp_zero});
      checkOutput($sformatf("vec%0d_rb", i), Rb_data, vecs[i].exp_rb);
    end

    // Store/load round trip, with one-edge read latency.
    loadConst(4'd4, 16'hBEEF);
    storeReg(4'd4, 8'h80);
    storeReg(4'd1, 8'h81);
    D_addr = 8'h81;
    tick();
    checkOutput("load_81", Mem_q, 16'h0005);
    D_addr = 8'h80;
    #1;
    checkOutput("load_latency", Mem_q, 16'h0005);
    tick();
    checkOutput("load_80", Mem_q, 16'hBEEF);
    RF_WenA    = 1'b1;
    RF_Ra_addr = 4'd7;
    tick();
    RF_WenA    = 1'b0;
    checkOutput("load_r7", Ra_data, 16'hBEEF);

    // Read-before-write on the same address.
    loadConst(4'd8, 16'h1111);
    loadConst(4'd11, 16'h2222);
    storeReg(4'd8, 8'h10);
    storeReg(4'd11, 8'h10);
    checkOutput("rbw_old", Mem_q, 16'h1111);
    tick();
    checkOutput("rbw_new", Mem_q, 16'h2222);

    // Write collision: ALU path wins on the same address.
    loadConst(4'd5, 16'hAAAA);
    storeReg(4'd5, 8'h20);
    D_addr = 8'h20;
    tick();
    checkOutput("coll_memq", Mem_q, 16'hAAAA);
    ALU_S      = 3'b110;
    RF_Ra_addr = 4'd5;
    RF_Rb_addr = 4'd5;
    RF_WenA    = 1'b1;
    RF_WenB    = 1'b1;
    tick();
    checkOutput("coll_same", Ra_data, 16'h5555);
    ALU_S      = 3'b000;
    RF_Rb_addr = 4'd6;
    tick();
    RF_WenA    = 1'b0;
    RF_WenB    = 1'b0;
    checkOutput("coll_diff_a", Ra_data, 16'hAAAA);
    checkOutput("coll_diff_b", Rb_data, 16'h5555);

    // Async reset between edges with every observable register non-zero.
    loadConst(4'd3, 16'h1234);
    storeReg(4'd3, 8'h01);
    D_addr = 8'h01;
    applyStimulus(3'b111, 4'd3, 4'd9, 1'b1);
    applyStimulus(3'b000, 4'd3, 4'd9, 1'b0);
    checkOutput("pre_alu", ALU_Out, 16'h1234);
    checkOutput("pre_memq", Mem_q, 16'h1234);
    checkOutput("pre_zero", {15'd0, Zero}, 16'h0001);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("areset_r3", Ra_data, 16'h0000);
    checkOutput("areset_alu", ALU_Out, 16'h0000);
    checkOutput("areset_memq", Mem_q, 16'h0000);
    checkOutput("areset_zero", {15'd0, Zero}, 16'h0000);
    #2;
    Reset      = 1'b1;
    RF_WenA    = 1'b1;
    RF_Ra_addr = 4'd7;
    tick();
    checkOutput("midload_r7", Ra_data, 16'h0000);
    checkOutput("midload_memq", Mem_q, 16'h1234);
    tick();
    RF_WenA = 1'b0;
    checkOutput("reload_r7", Ra_data, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
